// File: rtl/mcse_sha_arbiter.sv
// Arbiter sharing one SHA-256 core among NUM_REQ requesters.
// A winner is picked round-robin and keeps the core for its whole message.
// The core strobes and the requester ack are registered one-cycle pulses.
// Each block has a cycle budget of TIMEOUT; running out of it aborts the message.
module mcse_sha_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int TIMEOUT = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid_i,
    input  logic [NUM_REQ*512-1:0] req_block_i,
    input  logic [NUM_REQ-1:0]     req_last_i,
    output logic [NUM_REQ-1:0]     req_ack_o,
    output logic [NUM_REQ-1:0]     rsp_valid_o,
    output logic [255:0]           rsp_digest_o,
    output logic [511:0]           sha_block_o,
    output logic                   sha_init_o,
    output logic                   sha_next_o,
    input  logic                   sha_ready_i,
    input  logic [255:0]           sha_digest_i,
    input  logic                   sha_digest_valid_i,
    output logic                   busy_o,
    output logic [1:0]             owner_o,
    output logic                   err_timeout_o
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;

    state_e               state_q, state_d;
    logic [1:0]           owner_q, owner_d;
    logic [1:0]           last_owner_q, last_owner_d;
    logic                 first_q, first_d;
    logic                 last_q, last_d;
    logic                 wait_first_q, wait_first_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 err_q, err_d;
    logic [NUM_REQ-1:0]   ack_q, ack_d;
    logic [NUM_REQ-1:0]   rsp_q, rsp_d;
    logic [255:0]         digest_q, digest_d;
    logic                 init_q, init_d;
    logic                 next_q, next_d;

    logic [511:0]         blocks [NUM_REQ];
    logic [NUM_REQ-1:0]   owner_oh;
    logic                 rr_found;
    logic [1:0]           rr_idx;
    logic [1:0]           rr_cand;
    logic                 budget_out;

    // Split the flat block bus into one 512-bit word per requester.
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_split
        assign blocks[g] = req_block_i[g*512 +: 512];
    end

    assign owner_oh   = NUM_REQ'(1) << owner_q;
    assign budget_out = (cnt_q == CW'(TIMEOUT - 1));

    // Round-robin pick: first valid requester after the last owner, wrapping.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        rr_cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            rr_cand = 2'((int'(last_owner_q) + 1 + k) % NUM_REQ);
            if (!rr_found && req_valid_i[rr_cand]) begin
                rr_found = 1'b1;
                rr_idx   = rr_cand;
            end
        end
    end

    // Next-state and registered-output logic of the grant FSM.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        first_d      = first_q;
        last_d       = last_q;
        wait_first_d = wait_first_q;
        cnt_d        = cnt_q;
        err_d        = err_q;
        digest_d     = digest_q;
        ack_d        = '0;
        rsp_d        = '0;
        init_d       = 1'b0;
        next_d       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (rr_found) begin
                    owner_d = rr_idx;
                    first_d = 1'b1;
                    cnt_d   = '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d = cnt_q + CW'(1);
                if (budget_out) begin
                    err_d        = 1'b1;
                    last_owner_d = owner_q;
                    state_d      = IDLE;
                end else if (sha_ready_i && req_valid_i[owner_q]) begin
                    init_d       = first_q;
                    next_d       = !first_q;
                    ack_d        = owner_oh;
                    last_d       = req_last_i[owner_q];
                    first_d      = 1'b0;
                    wait_first_d = 1'b1;
                    state_d      = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q + CW'(1);
                if (budget_out) begin
                    err_d        = 1'b1;
                    last_owner_d = owner_q;
                    state_d      = IDLE;
                end else if (wait_first_q) begin
                    // The core still shows its pre-strobe status this cycle.
                    wait_first_d = 1'b0;
                end else if (sha_ready_i && sha_digest_valid_i) begin
                    if (last_q) begin
                        digest_d = sha_digest_i;
                        rsp_d    = owner_oh;
                        state_d  = DONE;
                    end else begin
                        cnt_d   = '0;
                        state_d = ISSUE;
                    end
                end
            end
            DONE: begin
                last_owner_d = owner_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            state_q      <= IDLE;
            owner_q      <= '0;
            last_owner_q <= 2'(NUM_REQ - 1);
            first_q      <= 1'b0;
            last_q       <= 1'b0;
            wait_first_q <= 1'b0;
            cnt_q        <= '0;
            err_q        <= 1'b0;
            ack_q        <= '0;
            rsp_q        <= '0;
            digest_q     <= '0;
            init_q       <= 1'b0;
            next_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            first_q      <= first_d;
            last_q       <= last_d;
            wait_first_q <= wait_first_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            ack_q        <= ack_d;
            rsp_q        <= rsp_d;
            digest_q     <= digest_d;
            init_q       <= init_d;
            next_q       <= next_d;
        end
    end

    assign busy_o        = (state_q != IDLE);
    assign owner_o       = owner_q;
    assign err_timeout_o = err_q;
    assign req_ack_o     = ack_q;
    assign rsp_valid_o   = rsp_q;
    assign rsp_digest_o  = digest_q;
    assign sha_init_o    = init_q;
    assign sha_next_o    = next_q;
    assign sha_block_o   = busy_o ? blocks[owner_q] : '0;

endmodule

// File: tb/tb_mcse_sha_arbiter.sv
// Directed bench for mcse_sha_arbiter: a vector table for single-block
// traffic plus hand-written multi-block, timeout and reset sequences.
module tb_mcse_sha_arbiter;

    localparam int NUM_REQ = 3;
    localparam int TIMEOUT = 16;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NUM_REQ-1:0]     req_valid_i;
    logic [NUM_REQ*512-1:0] req_block_i;
    logic [NUM_REQ-1:0]     req_last_i;
    logic [NUM_REQ-1:0]     req_ack_o;
    logic [NUM_REQ-1:0]     rsp_valid_o;
    logic [255:0]           rsp_digest_o;
    logic [511:0]           sha_block_o;
    logic                   sha_init_o;
    logic                   sha_next_o;
    logic                   sha_ready_i;
    logic [255:0]           sha_digest_i;
    logic                   sha_digest_valid_i;
    logic                   busy_o;
    logic [1:0]             owner_o;
    logic                   err_timeout_o;
    logic [31:0]            dig_tag;

    int checks = 0;
    int errors = 0;

    assign sha_digest_i = {8{dig_tag}};

    mcse_sha_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT)) dut (
        .clk                (clk),
        .rst                (rst),
        .req_valid_i        (req_valid_i),
        .req_block_i        (req_block_i),
        .req_last_i         (req_last_i),
        .req_ack_o          (req_ack_o),
        .rsp_valid_o        (rsp_valid_o),
        .rsp_digest_o       (rsp_digest_o),
        .sha_block_o        (sha_block_o),
        .sha_init_o         (sha_init_o),
        .sha_next_o         (sha_next_o),
        .sha_ready_i        (sha_ready_i),
        .sha_digest_i       (sha_digest_i),
        .sha_digest_valid_i (sha_digest_valid_i),
        .busy_o             (busy_o),
        .owner_o            (owner_o),
        .err_timeout_o      (err_timeout_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [2:0]  rv;
        logic [2:0]  rl;
        logic        rdy;
        logic        dv;
        logic [31:0] dtag;
        logic        e_busy;
        logic [1:0]  e_own;
        logic [2:0]  e_ack;
        logic        e_init;
        logic        e_next;
        logic [2:0]  e_rsp;
        logic [31:0] e_dtag;
        logic        e_err;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [511:0] blk(input logic [1:0] o);
        return {16{32'hB10C_0000 | 32'(o)}};
    endfunction

    function automatic vec_t mk(input logic r, input logic [2:0] rv, input logic [2:0] rl,
                                input logic rdy, input logic dv, input logic [31:0] dtag,
                                input logic e_busy, input logic [1:0] e_own, input logic [2:0] e_ack,
                                input logic e_init, input logic e_next, input logic [2:0] e_rsp,
                                input logic [31:0] e_dtag, input logic e_err);
        vec_t v;
        v.rst = r; v.rv = rv; v.rl = rl; v.rdy = rdy; v.dv = dv; v.dtag = dtag;
        v.e_busy = e_busy; v.e_own = e_own; v.e_ack = e_ack; v.e_init = e_init;
        v.e_next = e_next; v.e_rsp = e_rsp; v.e_dtag = e_dtag; v.e_err = e_err;
        return v;
    endfunction

    // Five cycles of one single-block message: grant, issue, stale WAIT, done, back to IDLE.
    task automatic add_msg(input logic [1:0] w, input logic [2:0] rv, input logic [2:0] rv_after,
                           input logic [31:0] tag, input logic [31:0] prev);
        logic [2:0] oh;
        oh = 3'b001 << w;
        tbl.push_back(mk(1'b0, rv, rv, 1'b1, 1'b0, tag, 1'b1, w, 3'b000, 1'b0, 1'b0, 3'b000, prev, 1'b0));
        tbl.push_back(mk(1'b0, rv, rv, 1'b1, 1'b0, tag, 1'b1, w, oh, 1'b1, 1'b0, 3'b000, prev, 1'b0));
        tbl.push_back(mk(1'b0, rv_after, rv_after, 1'b1, 1'b1, tag, 1'b1, w, 3'b000, 1'b0, 1'b0, 3'b000, prev, 1'b0));
        tbl.push_back(mk(1'b0, rv_after, rv_after, 1'b1, 1'b1, tag, 1'b1, w, 3'b000, 1'b0, 1'b0, oh, tag, 1'b0));
        tbl.push_back(mk(1'b0, rv_after, rv_after, 1'b1, 1'b0, tag, 1'b0, w, 3'b000, 1'b0, 1'b0, 3'b000, tag, 1'b0));
    endtask

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic [2:0] v, input logic [2:0] l,
                        input logic rdy, input logic dv);
        rst                = r;
        req_valid_i        = v;
        req_last_i         = l;
        sha_ready_i        = rdy;
        sha_digest_valid_i = dv;
        @(posedge clk);
        #1;
    endtask

    task automatic exp_outs(input string nm, input logic busy, input logic [1:0] own,
                            input logic [2:0] ack, input logic init, input logic nxt,
                            input logic [2:0] rsp);
        check($sformatf("%s.busy", nm), 512'(busy_o), 512'(busy));
        check($sformatf("%s.owner", nm), 512'(owner_o), 512'(own));
        check($sformatf("%s.ack", nm), 512'(req_ack_o), 512'(ack));
        check($sformatf("%s.init", nm), 512'(sha_init_o), 512'(init));
        check($sformatf("%s.next", nm), 512'(sha_next_o), 512'(nxt));
        check($sformatf("%s.rsp", nm), 512'(rsp_valid_o), 512'(rsp));
        check($sformatf("%s.block", nm), sha_block_o, busy ? blk(own) : 512'd0);
    endtask

    initial begin
        for (int i = 0; i < NUM_REQ; i++) req_block_i[i*512 +: 512] = blk(2'(i));
        dig_tag = 32'h0;
        step(1'b1, 3'b000, 3'b000, 1'b0, 1'b0);
        step(1'b1, 3'b000, 3'b000, 1'b0, 1'b0);

        // Reset row, contention 0,1,2,0 from reset, then a lone single-block message.
        tbl.push_back(mk(1'b1, 3'b000, 3'b000, 1'b0, 1'b0, 32'h0, 1'b0, 2'd0, 3'b000, 1'b0, 1'b0, 3'b000, 32'h0, 1'b0));
        add_msg(2'd0, 3'b111, 3'b111, 32'hD000_00A0, 32'h0);
        add_msg(2'd1, 3'b111, 3'b111, 32'hD000_00B1, 32'hD000_00A0);
        add_msg(2'd2, 3'b111, 3'b111, 32'hD000_00C2, 32'hD000_00B1);
        add_msg(2'd0, 3'b111, 3'b111, 32'hD000_00D0, 32'hD000_00C2);
        add_msg(2'd0, 3'b001, 3'b000, 32'hD000_00E0, 32'hD000_00D0);

        for (int i = 0; i < tbl.size(); i++) begin
            dig_tag = tbl[i].dtag;
            step(tbl[i].rst, tbl[i].rv, tbl[i].rl, tbl[i].rdy, tbl[i].dv);
            exp_outs($sformatf("vec%0d", i), tbl[i].e_busy, tbl[i].e_own, tbl[i].e_ack,
                     tbl[i].e_init, tbl[i].e_next, tbl[i].e_rsp);
            check($sformatf("vec%0d.digest", i), 512'(rsp_digest_o), 512'({8{tbl[i].e_dtag}}));
            check($sformatf("vec%0d.err", i), 512'(err_timeout_o), 512'(tbl[i].e_err));
        end

        // Multi-block lock: requester 1 sends three blocks while requester 0 waits.
        dig_tag = 32'hD00D_0001;
        step(1'b1, 3'b000, 3'b000, 1'b0, 1'b0);
        step(1'b0, 3'b010, 3'b000, 1'b1, 1'b0); exp_outs("mb.grant", 1'b1, 2'd1, 3'b000, 1'b0, 1'b0, 3'b000);
        step(1'b0, 3'b011, 3'b000, 1'b1, 1'b0); exp_outs("mb.init", 1'b1, 2'd1, 3'b010, 1'b1, 1'b0, 3'b000);
        step(1'b0, 3'b011, 3'b000, 1'b1, 1'b1); exp_outs("mb.stale1", 1'b1, 2'd1, 3'b000, 1'b0, 1'b0, 3'b000);
        step(1'b0, 3'b011, 3'b000, 1'b1, 1'b1); exp_outs("mb.cont1", 1'b1, 2'd1, 3'b000, 1'b0, 1'b0, 3'b000);
        step(1'b0, 3'b011, 3'b000, 1'b1, 1'b0); exp_outs("mb.next1", 1'b1, 2'd1, 3'b010, 1'b0, 1'b1, 3'b000);
        step(1'b0, 3'b001, 3'b000, 1'b1, 1'b1); exp_outs("mb.stale2", 1'b1, 2'd1, 3'b000, 1'b0, 1'b0, 3'b000);
        step(1'b0, 3'b001, 3'b000, 1'b1, 1'b1); exp_outs("mb.cont2", 1'b1, 2'd1, 3'b000, 1'b0, 1'b0, 3'b000);
        step(1'b0, 3'b001, 3'b001, 1'b1, 1'b0); exp_outs("mb.dropheld", 1'b1, 2'd1, 3'b000, 1'b0, 1'b0, 3'b000);
        step(1'b0, 3'b011, 3'b010, 1'b1, 1'b0); exp_outs("mb.next2", 1'b1, 2'd1, 3'b010, 1'b0, 1'b1, 3'b000);
        step(1'b0, 3'b001, 3'b001, 1'b1, 1'b1); exp_outs("mb.stale3", 1'b1, 2'd1, 3'b000, 1'b0, 1'b0, 3'b000);
        step(1'b0, 3'b001, 3'b001, 1'b1, 1'b1); exp_outs("mb.done", 1'b1, 2'd1, 3'b000, 1'b0, 1'b0, 3'b010);
        check("mb.digest", 512'(rsp_digest_o), 512'({8{32'hD00D_0001}}));
        step(1'b0, 3'b001, 3'b001, 1'b1, 1'b0); exp_outs("mb.idle", 1'b0, 2'd1, 3'b000, 1'b0, 1'b0, 3'b000);
        step(1'b0, 3'b001, 3'b001, 1'b1, 1'b0); exp_outs("mb.grant0", 1'b1, 2'd0, 3'b000, 1'b0, 1'b0, 3'b000);
        step(1'b0, 3'b001, 3'b001, 1'b1, 1'b0); exp_outs("mb.init0", 1'b1, 2'd0, 3'b001, 1'b1, 1'b0, 3'b000);

        // Timeout: core never ready, budget of 16 ISSUE cycles, then requester 1 served.
        step(1'b1, 3'b000, 3'b000, 1'b0, 1'b0);
        step(1'b0, 3'b001, 3'b001, 1'b0, 1'b0); exp_outs("to.grant", 1'b1, 2'd0, 3'b000, 1'b0, 1'b0, 3'b000);
        for (int i = 1; i < TIMEOUT; i++) begin
            step(1'b0, 3'b011, 3'b011, 1'b0, 1'b0);
            exp_outs($sformatf("to.cyc%0d", i), 1'b1, 2'd0, 3'b000, 1'b0, 1'b0, 3'b000);
            check($sformatf("to.cyc%0d.err", i), 512'(err_timeout_o), 512'd0);
        end
        step(1'b0, 3'b011, 3'b011, 1'b0, 1'b0);
        exp_outs("to.abort", 1'b0, 2'd0, 3'b000, 1'b0, 1'b0, 3'b000);
        check("to.abort.err", 512'(err_timeout_o), 512'd1);
        step(1'b0, 3'b011, 3'b011, 1'b1, 1'b0); exp_outs("to.grant1", 1'b1, 2'd1, 3'b000, 1'b0, 1'b0, 3'b000);
        check("to.sticky", 512'(err_timeout_o), 512'd1);
        step(1'b0, 3'b011, 3'b011, 1'b1, 1'b0); exp_outs("to.init1", 1'b1, 2'd1, 3'b010, 1'b1, 1'b0, 3'b000);

        // Reset mid-WAIT: everything returns to reset values and no response follows.
        dig_tag = 32'hD00D_0002;
        step(1'b1, 3'b000, 3'b000, 1'b1, 1'b1);
        exp_outs("rw.reset", 1'b0, 2'd0, 3'b000, 1'b0, 1'b0, 3'b000);
        check("rw.err", 512'(err_timeout_o), 512'd0);
        check("rw.digest", 512'(rsp_digest_o), 512'd0);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 3'b000, 3'b000, 1'b1, 1'b1);
            exp_outs($sformatf("rw.after%0d", i), 1'b0, 2'd0, 3'b000, 1'b0, 1'b0, 3'b000);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
